rc4_sbox_engine: RTL

- Parametrised successor to the S-array initialiser in the RC4 decrypt datapath.
- Drives the single-port S-memory through two phases:
  - init: s[i] = i for every address.
  - optional key-scheduling (KSA) shuffle: j = j + s[i] + key[i mod KEY_BYTES], then swap s[i] and s[j].
- Sits between the top-level controller (start/finished handshake) and the S on-chip RAM. The decrypt loop starts only after finished.

---
 rtl/rc4_sbox_engine.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rc4_sbox_engine.sv
// RC4 S-array engine: fills S-memory with the identity permutation, then optionally runs the KSA shuffle.
// Build option: define RC4_SWAP_SKIP_EN to skip both swap writes when j==i (4-cycle iteration).
module rc4_sbox_engine #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [ADDR_W-1:0]      address,
    output logic [ADDR_W-1:0]      data,
    output logic                   wren,
    input  logic [ADDR_W-1:0]      q,
    output logic                   busy,
    output logic                   finished
);

    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_RD_I, S_WAIT_I, S_RD_J, S_WAIT_J, S_WR_I, S_WR_J, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [ADDR_W-1:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KIDX_W-1:0]      kidx_q, kidx_d;
    logic [7:0]             kb8;
    logic [ADDR_W-1:0]      kb;
    logic                   advance;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            key_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            key_q   <= key_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
        end
    end

    // Key byte 0 sits in the most significant byte of the key.
    always_comb begin
        kb8 = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == KIDX_W'(b)) kb8 = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
    end

    if (ADDR_W > 8) begin : g_kb_ext
        assign kb = {{(ADDR_W-8){1'b0}}, kb8};
    end else begin : g_kb_trunc
        assign kb = kb8[ADDR_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        key_d    = key_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        sj_d     = sj_q;
        kidx_d   = kidx_q;
        address  = '0;
        data     = '0;
        wren     = 1'b0;
        busy     = (state_q != S_IDLE);
        finished = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    key_d   = secret_key;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                address = i_q;
                data    = i_q;
                wren    = 1'b1;
                i_d     = i_q + ADDR_W'(1);
                if (i_q == '1) state_d = mode_q ? S_RD_I : S_DONE;
            end
            S_RD_I: begin
                address = i_q;
                state_d = S_WAIT_I;
            end
            S_WAIT_I: begin
                si_d    = q;
                j_d     = j_q + q + kb;
                state_d = S_RD_J;
            end
            S_RD_J: begin
                address = j_q;
                state_d = S_WAIT_J;
            end
            S_WAIT_J: begin
                sj_d = q;
`ifdef RC4_SWAP_SKIP_EN
                if (j_q == i_q) advance = 1'b1;
                else            state_d = S_WR_I;
`else
                state_d = S_WR_I;
`endif
            end
            S_WR_I: begin
                address = i_q;
                data    = sj_q;
                wren    = 1'b1;
                state_d = S_WR_J;
            end
            S_WR_J: begin
                // When i==j both writes carry the same value, so write order settles the swap.
                address = j_q;
                data    = si_q;
                wren    = 1'b1;
                advance = 1'b1;
            end
            S_DONE: begin
                finished = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            i_d     = i_q + ADDR_W'(1);
            kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
            state_d = (i_q == '1) ? S_DONE : S_RD_I;
        end
    end

endmodule
